// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//
// Sequences simple register-file operations (LOAD, MOVE, SWAP, CLEAR) onto a
// register file with four general registers R1..R4 and four scratch registers
// S1..S4. It accepts one request at a time, reads operands when needed, and
// drives one-hot write enables for one or two write cycles.
//
// Ports:
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   ReqValid/ReqReady    request handshake (ready only while idle)
//   ReqOp                00 LOAD, 01 MOVE, 10 SWAP, 11 CLEAR
//   ReqSrc, ReqDst       register indices: 0..3 = R1..R4, 4..7 = S1..S4
//   ReqImm               immediate for LOAD
//   RfI                  write data to the register file
//   RfFunSel             010 = load I, 011 = clear
//   RfRegSel, RfScrSel   write enables, bit3 = R1/S1 .. bit0 = R4/S4
//   RfOutASel/BSel       read port selects
//   RfOutA/B             read port data
//   Done, DoneData       completion strobe and value written in the final write
// -----------------------------------------------------------------------------
module regfile_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  ReqOp,
    input  logic [2:0]  ReqSrc,
    input  logic [2:0]  ReqDst,
    input  logic [31:0] ReqImm,
    output logic [31:0] RfI,
    output logic [2:0]  RfFunSel,
    output logic [3:0]  RfRegSel,
    output logic [3:0]  RfScrSel,
    output logic [2:0]  RfOutASel,
    output logic [2:0]  RfOutBSel,
    input  logic [31:0] RfOutA,
    input  logic [31:0] RfOutB,
    output logic        Done,
    output logic [31:0] DoneData
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpMove  = 2'b01;
    localparam logic [1:0] OpSwap  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    localparam logic [2:0] FunLoad  = 3'b010;
    localparam logic [2:0] FunClear = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite1,
        StWrite2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [2:0]  src_q;
    logic [2:0]  dst_q;
    logic [31:0] imm_q;
    logic [31:0] hold_a_q;
    logic [31:0] hold_b_q;
    logic [31:0] done_data_q;

    logic        accept;
    logic        wr_en;
    logic [2:0]  wr_idx;

    assign accept = ReqValid & ReqReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            op_q        <= OpLoad;
            src_q       <= 3'd0;
            dst_q       <= 3'd0;
            imm_q       <= 32'd0;
            hold_a_q    <= 32'd0;
            hold_b_q    <= 32'd0;
            done_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= ReqOp;
                src_q <= ReqSrc;
                dst_q <= ReqDst;
                imm_q <= ReqImm;
            end
            if (state_q == StRead) begin
                hold_a_q <= RfOutA;
                hold_b_q <= RfOutB;
            end
            if (Done) begin
                done_data_q <= RfI;
            end
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_d   = state_q;
        ReqReady  = 1'b0;
        RfI       = 32'd0;
        RfFunSel  = FunLoad;
        RfOutASel = 3'd0;
        RfOutBSel = 3'd0;
        wr_en     = 1'b0;
        wr_idx    = dst_q;
        Done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    state_d = (ReqOp == OpLoad || ReqOp == OpClear) ? StWrite1 : StRead;
                end
            end
            StRead: begin
                RfOutASel = src_q;
                RfOutBSel = dst_q;
                state_d   = StWrite1;
            end
            StWrite1: begin
                wr_en = 1'b1;
                // SWAP writes the old destination value into the source first.
                wr_idx = (op_q == OpSwap) ? src_q : dst_q;
                unique case (op_q)
                    OpLoad:  RfI = imm_q;
                    OpClear: begin
                        RfFunSel = FunClear;
                        RfI      = 32'd0;
                    end
                    OpMove:  RfI = hold_a_q;
                    OpSwap:  RfI = hold_b_q;
                    default: RfI = 32'd0;
                endcase
                if (op_q == OpSwap) begin
                    state_d = StWrite2;
                end else begin
                    state_d = StIdle;
                    Done    = 1'b1;
                end
            end
            StWrite2: begin
                wr_en   = 1'b1;
                wr_idx  = dst_q;
                RfI     = hold_a_q;
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Index 0..3 maps to RegSel bit 3-idx, 4..7 to ScrSel bit 7-idx.
    always_comb begin
        RfRegSel = 4'b0000;
        RfScrSel = 4'b0000;
        if (wr_en) begin
            if (!wr_idx[2]) begin
                RfRegSel[2'd3 - wr_idx[1:0]] = 1'b1;
            end else begin
                RfScrSel[2'd3 - wr_idx[1:0]] = 1'b1;
            end
        end
    end

    assign DoneData = Done ? RfI : done_data_q;

endmodule
